// File: rtl/sa_ram_pkg.sv
// Shared definitions for the parametrised sa_ram family.
package sa_ram_pkg;

  // Read-during-write behaviour for a same-cycle read and write to one address.
  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  // Control FSM states.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sa_ram_state_e;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned sa_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sa_ram_init_seq.sv
// Post-reset sequencer: walks every address writing zero, then flags the array ready.
module sa_ram_init_seq
  import sa_ram_pkg::*;
#(
  parameter int unsigned DEPTH   = 60,
  parameter int unsigned AW      = 6,
  parameter int unsigned INIT_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_we,
  output logic [AW-1:0] init_wa,
  output logic          init_done
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  sa_ram_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Next state: step the address counter, leave INIT after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      ST_INIT: begin
        if ((INIT_EN == 0) || (cnt_q == LastAddr)) begin
          state_d = ST_READY;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
    endcase
  end

  // State registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign init_we   = (state_q == ST_INIT) && (INIT_EN != 0);
  assign init_wa   = cnt_q;
  assign init_done = done_q;

endmodule

// File: rtl/sa_ram_rwsthp_param.sv
// Parametrised 1R1W RAM with registered read address and registered output stage.
module sa_ram_rwsthp_param
  import sa_ram_pkg::*;
#(
  parameter int unsigned WIDTH    = 84,
  parameter int unsigned DEPTH    = 60,
  parameter int unsigned AW       = 6,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned INIT_EN  = 1
) (
  input  logic             clk,
  input  logic             nvdla_core_rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  output logic             init_done,
  output logic             addr_err,
  input  logic [31:0]      pwrbus_ram_pd
);

  if (AW < sa_clog2(DEPTH)) begin : g_aw_check
    $error("sa_ram_rwsthp_param: AW too small for DEPTH");
  end

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic             unused_pd;
  logic             init_we;
  logic [AW-1:0]    init_wa;
  logic             ready;
  logic             wa_ok, ra_ok, rd_ok, acc_we, acc_re, collide;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    ra_d_q, ra_d_d;
  logic             s1_vld_q, s1_vld_d;
  logic             fwd_sel_q, fwd_sel_d;
  logic [WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             addr_err_q, addr_err_d;

  assign unused_pd = ^pwrbus_ram_pd;

  sa_ram_init_seq #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .INIT_EN(INIT_EN)
  ) u_init_seq (
    .clk      (clk),
    .rst_n    (nvdla_core_rstn),
    .init_we  (init_we),
    .init_wa  (init_wa),
    .init_done(ready)
  );

  assign wa_ok   = {1'b0, wa} < DepthW;
  assign ra_ok   = {1'b0, ra} < DepthW;
  assign rd_ok   = {1'b0, ra_d_q} < DepthW;
  assign acc_we  = ready & we;
  assign acc_re  = ready & re;
  assign collide = acc_re & acc_we & ra_ok & wa_ok & (ra == wa);

  // Init sweep owns the write port until it finishes.
  assign mem_we = init_we | (acc_we & wa_ok);
  assign mem_wa = init_we ? init_wa : wa;
  assign mem_wd = init_we ? '0 : di;

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign s1_data = fwd_sel_q ? fwd_data_q : (rd_ok ? mem[ra_d_q] : '0);

  // Next state for read stage 1, collision capture, output stage and error flag.
  always_comb begin
    ra_d_d     = ra_d_q;
    s1_vld_d   = s1_vld_q;
    fwd_sel_d  = fwd_sel_q;
    fwd_data_d = fwd_data_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    addr_err_d = addr_err_q | (acc_re & ~ra_ok) | (acc_we & ~wa_ok);
    if (acc_re) begin
      ra_d_d   = ra;
      s1_vld_d = 1'b1;
    end
    if (RDW_MODE == RDW_NEW) begin
      if (collide) begin
        fwd_sel_d  = 1'b1;
        fwd_data_d = di;
      end else if (acc_re) begin
        fwd_sel_d = 1'b0;
      end
    end else begin
      // The colliding write lands this edge, so hold the old word for the next cycle only.
      fwd_sel_d = collide;
      if (collide) fwd_data_d = mem[ra];
    end
    if (ore) begin
      dout_d     = byp_sel ? dbyp : s1_data;
      dout_vld_d = byp_sel | s1_vld_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ra_d_q     <= '0;
      s1_vld_q   <= 1'b0;
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      ra_d_q     <= ra_d_d;
      s1_vld_q   <= s1_vld_d;
      fwd_sel_q  <= fwd_sel_d;
      fwd_data_q <= fwd_data_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign init_done = ready;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_sa_ram_rwsthp_param.sv
// Bench for sa_ram_rwsthp_param: old-data, new-data and no-init instances driven in parallel.
module tb_sa_ram_rwsthp_param;

  localparam int W = 84;
  localparam int D = 60;
  localparam int A = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic [A-1:0]  ra, wa;
  logic          re, we, ore, byp;
  logic [W-1:0]  di, dbyp;
  logic [31:0]   pd;

  logic [W-1:0]  dout0, dout1, dout2;
  logic          vld0, vld1, vld2, done0, done1, done2, err0, err1, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_ram_rwsthp_param #(.WIDTH(W), .DEPTH(D), .AW(A), .RDW_MODE(0), .INIT_EN(1)) u_old (
    .clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout0),
    .dout_vld(vld0), .wa(wa), .we(we), .di(di), .byp_sel(byp), .dbyp(dbyp),
    .init_done(done0), .addr_err(err0), .pwrbus_ram_pd(pd)
  );

  sa_ram_rwsthp_param #(.WIDTH(W), .DEPTH(D), .AW(A), .RDW_MODE(1), .INIT_EN(1)) u_new (
    .clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout1),
    .dout_vld(vld1), .wa(wa), .we(we), .di(di), .byp_sel(byp), .dbyp(dbyp),
    .init_done(done1), .addr_err(err1), .pwrbus_ram_pd(pd)
  );

  sa_ram_rwsthp_param #(.WIDTH(W), .DEPTH(D), .AW(A), .RDW_MODE(0), .INIT_EN(0)) u_noinit (
    .clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout2),
    .dout_vld(vld2), .wa(wa), .we(we), .di(di), .byp_sel(byp), .dbyp(dbyp),
    .init_done(done2), .addr_err(err2), .pwrbus_ram_pd(pd)
  );

  // Reference model: the RAM as the user sees it, one copy of read state per RDW flavour.
  logic [W-1:0] m_mem [D];
  logic [A-1:0] m_ra_d;
  bit           m_s1v, m_err;
  bit           m_fsel [2];
  logic [W-1:0] m_fdat [2];
  logic [W-1:0] m_dout [2];
  bit           m_vld  [2];
  int           m_edges;

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_ra_d = '0; m_s1v = 0; m_err = 0; m_edges = 0;
    for (int k = 0; k < 2; k++) begin
      m_fsel[k] = 0; m_fdat[k] = '0; m_dout[k] = '0; m_vld[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] s1;
    bit ready, coll;
    if (!rstn) begin
      model_reset();
      return;
    end
    ready = (m_edges >= D);
    if (m_edges < 1000000) m_edges++;
    for (int k = 0; k < 2; k++) begin
      if (m_fsel[k]) s1 = m_fdat[k];
      else if (int'(m_ra_d) < D) s1 = m_mem[m_ra_d];
      else s1 = '0;
      if (ore) begin
        m_dout[k] = byp ? dbyp : s1;
        m_vld[k]  = byp | m_s1v;
      end
    end
    if (ready) begin
      coll = re && we && (ra == wa) && (int'(ra) < D);
      m_fsel[0] = coll;
      if (coll) m_fdat[0] = m_mem[ra];
      if (coll) begin
        m_fsel[1] = 1; m_fdat[1] = di;
      end else if (re) begin
        m_fsel[1] = 0;
      end
      if (re) begin
        m_ra_d = ra; m_s1v = 1;
        if (int'(ra) >= D) m_err = 1;
      end
      if (we) begin
        if (int'(wa) < D) m_mem[wa] = di;
        else m_err = 1;
      end
    end else begin
      m_fsel[0] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dout_old"}, dout0, m_dout[0]);
    chk({tag, "_dout_new"}, dout1, m_dout[1]);
    chk({tag, "_vld_old"}, W'(vld0), W'(m_vld[0]));
    chk({tag, "_vld_new"}, W'(vld1), W'(m_vld[1]));
    chk({tag, "_err"}, W'(err0), W'(m_err));
  endtask

  task automatic idle();
    re = 0; we = 0; ore = 0; byp = 0; ra = '0; wa = '0; di = '0; dbyp = '0;
  endtask

  // Count cycles from reset release to init_done (bounded).
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!done0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_init_cycles"}, W'(n), W'(D));
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < D; a++) begin
      re = 1; ra = A'(a);
      tick();
      re = 0; ore = 1;
      tick();
      ore = 0;
      chk($sformatf("%s_zero%0d_old", tag, a), dout0, '0);
      chk($sformatf("%s_zero%0d_new", tag, a), dout1, '0);
      chk($sformatf("%s_vld%0d", tag, a), W'(vld0), W'(1));
    end
  endtask

  typedef struct {
    bit           we;
    logic [A-1:0] wa;
    logic [W-1:0] di;
    bit           re;
    logic [A-1:0] ra;
    bit           ore;
    bit           byp;
    logic [W-1:0] dbyp;
    logic [W-1:0] e_old;
    logic [W-1:0] e_new;
    bit           e_vld;
    bit           e_err;
  } vec_t;

  function automatic vec_t mk(bit we_, int wa_, logic [W-1:0] di_, bit re_, int ra_, bit ore_,
                              bit byp_, logic [W-1:0] dbyp_, logic [W-1:0] eo,
                              logic [W-1:0] en, bit ev, bit ee);
    vec_t v;
    v.we = we_; v.wa = A'(wa_); v.di = di_; v.re = re_; v.ra = A'(ra_); v.ore = ore_;
    v.byp = byp_; v.dbyp = dbyp_; v.e_old = eo; v.e_new = en; v.e_vld = ev; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [95:0] r96;

    // we   wa  di       re ra  ore byp dbyp    exp_old  exp_new  vld err
    tbl[0]  = mk(1, 5,  84'hABC, 0, 0,  0, 0, '0,     '0,      '0,      1, 0);
    tbl[1]  = mk(0, 0,  '0,      1, 5,  0, 0, '0,     '0,      '0,      1, 0);
    tbl[2]  = mk(0, 0,  '0,      0, 0,  1, 0, '0,     84'hABC, 84'hABC, 1, 0);
    tbl[3]  = mk(1, 7,  84'h11,  0, 0,  0, 0, '0,     84'hABC, 84'hABC, 1, 0);
    tbl[4]  = mk(1, 7,  84'h55,  1, 7,  0, 0, '0,     84'hABC, 84'hABC, 1, 0);
    tbl[5]  = mk(0, 0,  '0,      0, 0,  1, 0, '0,     84'h11,  84'h55,  1, 0);
    tbl[6]  = mk(1, 60, 84'hFFFF, 0, 0, 0, 0, '0,     84'h11,  84'h55,  1, 1);
    tbl[7]  = mk(0, 0,  '0,      1, 63, 0, 0, '0,     84'h11,  84'h55,  1, 1);
    tbl[8]  = mk(0, 0,  '0,      0, 0,  1, 0, '0,     '0,      '0,      1, 1);
    tbl[9]  = mk(0, 0,  '0,      1, 59, 0, 0, '0,     '0,      '0,      1, 1);
    tbl[10] = mk(1, 59, 84'h77,  0, 0,  1, 0, '0,     '0,      '0,      1, 1);
    tbl[11] = mk(0, 0,  '0,      0, 0,  1, 0, '0,     84'h77,  84'h77,  1, 1);
    tbl[12] = mk(0, 0,  '0,      0, 0,  1, 1, 84'h3C, 84'h3C,  84'h3C,  1, 1);

    pd = 32'h0;
    idle();
    rstn = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_dout", dout0, '0);
    chk("rst_vld", W'(vld0), W'(0));
    chk("rst_done", W'(done0), W'(0));
    chk("rst_err", W'(err0), W'(0));
    chk("rst_done_noinit", W'(done2), W'(0));

    // Release, bypass during INIT, count to init_done.
    rstn = 1'b1;
    begin
      int n;
      n = 0;
      while (!done0 && n < 200) begin
        if (n == 9) begin
          byp = 1; dbyp = 84'h3C; ore = 1;
        end
        tick();
        n++;
        if (n == 1) chk("noinit_ready_1cyc", W'(done2), W'(1));
        if (n == 10) begin
          chk("init_byp_dout", dout0, 84'h3C);
          chk("init_byp_vld", W'(vld0), W'(1));
          chk("init_done_low", W'(done0), W'(0));
          idle();
        end
      end
      chk("init_cycles", W'(n), W'(D));
    end
    chk("init_done_new", W'(done1), W'(1));

    sweep("post_init");

    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; di = tbl[i].di; re = tbl[i].re; ra = tbl[i].ra;
      ore = tbl[i].ore; byp = tbl[i].byp; dbyp = tbl[i].dbyp;
      tick();
      chk($sformatf("tbl%0d_dout_old", i), dout0, tbl[i].e_old);
      chk($sformatf("tbl%0d_dout_new", i), dout1, tbl[i].e_new);
      chk($sformatf("tbl%0d_vld", i), W'(vld0), W'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_err", i), W'(err0), W'(tbl[i].e_err));
      check_model($sformatf("tbl%0d_model", i));
    end
    idle();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      re  = ($urandom_range(1) == 1);
      ra  = ($urandom_range(7) == 0) ? A'($urandom_range(63)) : A'($urandom_range(D - 1));
      we  = ($urandom_range(2) == 0);
      wa  = ($urandom_range(3) == 0) ? ra : A'($urandom_range(D - 1));
      if ($urandom_range(31) == 0) wa = A'($urandom_range(63));
      r96 = {$urandom(), $urandom(), $urandom()};
      di  = r96[W-1:0];
      ore = ($urandom_range(1) == 1);
      byp = ($urandom_range(9) == 0);
      r96 = {$urandom(), $urandom(), $urandom()};
      dbyp = r96[W-1:0];
      tick();
      check_model($sformatf("rnd%0d", c));
    end
    idle();

    // Reset clears sticky error; reset again mid-INIT and restart the sweep.
    rstn = 1'b0;
    repeat (2) tick();
    chk("rst2_err", W'(err0), W'(0));
    chk("rst2_vld", W'(vld1), W'(0));
    chk("rst2_done", W'(done0), W'(0));
    rstn = 1'b1;
    repeat (30) tick();
    chk("mid_init_done_low", W'(done0), W'(0));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wait_init("restart");
    sweep("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
